// File: rtl/output_port_arbiter_if.sv
// rtl/output_port_arbiter_if.sv - request/grant/transfer bundle between router datapath and one output-port arbiter
interface output_port_arbiter_if;
    logic [3:0] request_vector_din;
    logic       port_ready_din;
    logic       flit_transfer_din;
    logic [3:0] grant_vector_dout;
    logic [1:0] xbar_sel_dout;
    logic       port_busy_dout;
    logic       timeout_dout;

    // Router side: presents requests and flit activity, observes the grant
    modport master (
        output request_vector_din,
        output port_ready_din,
        output flit_transfer_din,
        input  grant_vector_dout,
        input  xbar_sel_dout,
        input  port_busy_dout,
        input  timeout_dout
    );

    // Arbiter side
    modport slave (
        input  request_vector_din,
        input  port_ready_din,
        input  flit_transfer_din,
        output grant_vector_dout,
        output xbar_sel_dout,
        output port_busy_dout,
        output timeout_dout
    );
endinterface

// File: rtl/output_port_arbiter.sv
// rtl/output_port_arbiter.sv - round-robin output-port arbiter holding a one-hot grant per packet; optional GRANT_TIMEOUT_EN
`ifndef X_POS
`define X_POS 1
`endif

module output_port_arbiter #(
    parameter int PORT_DIR       = `X_POS,
    parameter int PACKET_FLITS   = 5,
    parameter int CNT_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    output_port_arbiter_if.slave  bus
);

    typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_FLIT = CNT_WIDTH'(PACKET_FLITS - 1);

    // Parameter sanity: a bad instance fails at elaboration instead of misbehaving
    if (PACKET_FLITS < 2 || PACKET_FLITS > 15 || (PACKET_FLITS - 1) >= (1 << CNT_WIDTH) ||
        TIMEOUT_CYCLES < 1 || PORT_DIR < 0 || PORT_DIR > 4) begin : g_bad_param
        $error("output_port_arbiter: illegal parameter combination");
    end

    state_t                 r_state;
    logic [3:0]             r_grant;
    logic [1:0]             r_sel;
    logic [1:0]             r_ptr;
    logic [CNT_WIDTH-1:0]   r_cnt;

    state_t                 w_state_nxt;
    logic [3:0]             w_grant_nxt;
    logic [1:0]             w_sel_nxt;
    logic [1:0]             w_ptr_nxt;
    logic [CNT_WIDTH-1:0]   w_cnt_nxt;

    logic                   w_found;
    logic [1:0]             w_winner;
    logic [1:0]             w_idx;

`ifdef GRANT_TIMEOUT_EN
    localparam int                 STALL_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_LAST  = STALL_W'(TIMEOUT_CYCLES - 1);

    logic [STALL_W-1:0]     r_stall;
    logic [STALL_W-1:0]     w_stall_nxt;
    logic                   r_timeout;
    logic                   w_timeout_nxt;
`endif

    // Rotating priority search: first requester at or after the pointer wins
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_idx    = r_ptr;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && bus.request_vector_din[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Next-state logic: grant on idle request, count flits, release after the last one
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
`ifdef GRANT_TIMEOUT_EN
        w_stall_nxt   = r_stall;
        w_timeout_nxt = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found && bus.port_ready_din) begin
                    w_state_nxt = S_ACTIVE;
                    w_grant_nxt = 4'b0001 << w_winner;
                    w_sel_nxt   = w_winner;
                    w_cnt_nxt   = '0;
`ifdef GRANT_TIMEOUT_EN
                    w_stall_nxt = '0;
`endif
                end
            end
            S_ACTIVE: begin
                if (bus.flit_transfer_din) begin
`ifdef GRANT_TIMEOUT_EN
                    w_stall_nxt = '0;
`endif
                    if (r_cnt == LAST_FLIT) begin
                        w_state_nxt = S_IDLE;
                        w_grant_nxt = 4'b0000;
                        w_cnt_nxt   = '0;
                        w_ptr_nxt   = r_sel + 2'd1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
`ifdef GRANT_TIMEOUT_EN
                else if (r_stall == STALL_LAST) begin
                    // Downstream stuck too long: give the port up like a normal release
                    w_state_nxt   = S_IDLE;
                    w_grant_nxt   = 4'b0000;
                    w_cnt_nxt     = '0;
                    w_ptr_nxt     = r_sel + 2'd1;
                    w_stall_nxt   = '0;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_stall_nxt = r_stall + 1'b1;
                end
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = 4'b0000;
            end
        endcase
    end

    // State and output registers; reset abandons any packet in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_grant <= 4'b0000;
            r_sel   <= 2'd0;
            r_ptr   <= 2'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef GRANT_TIMEOUT_EN
    // Stall counter and one-cycle timeout pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_stall   <= w_stall_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign bus.timeout_dout = r_timeout;
`else
    assign bus.timeout_dout = 1'b0;
`endif

    assign bus.grant_vector_dout = r_grant;
    assign bus.xbar_sel_dout     = r_sel;
    assign bus.port_busy_dout    = (r_state == S_ACTIVE);

endmodule
